// File: rtl/seq_matcher_pkg.sv
// Shared types, mode encodings and helpers for the programmable sequence matcher.
package seq_matcher_pkg;

  typedef enum logic [1:0] {
    UNCFG = 2'd0,
    ARMED = 2'd1,
    ERR   = 2'd2
  } sm_state_e;

  localparam logic OVERLAP     = 1'b1;
  localparam logic NON_OVERLAP = 1'b0;

  // Widest pattern the matcher can ever be built for; callers slice the result.
  localparam int unsigned LEN_MASK_W = 64;

  // Thermometer mask with bits [len-1:0] set.
  function automatic logic [LEN_MASK_W-1:0] len_mask(input int unsigned len);
    logic [LEN_MASK_W-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < LEN_MASK_W; i++) begin
      m[i] = (i < len);
    end
    return m;
  endfunction

endpackage

// File: rtl/seq_match_cmp.sv
// Masked comparator: history equals pattern on every cared-for bit below len.
module seq_match_cmp
  import seq_matcher_pkg::*;
#(
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic [MAX_LEN-1:0] hist_next,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [MAX_LEN-1:0] mask,
  input  logic [LEN_W-1:0]   len,
  output logic               eq
);

  logic [MAX_LEN-1:0] lenmask;

  // Bits outside the pattern length or masked off never cause a mismatch.
  always_comb begin
    lenmask = MAX_LEN'(len_mask(32'(len)));
    eq      = ((hist_next ^ pattern) & mask & lenmask) == '0;
  end

endmodule

// File: rtl/seq_matcher.sv
// Programmable serial pattern detector with masked compare and saturating match count.
module seq_matcher
  import seq_matcher_pkg::*;
#(
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [MAX_LEN-1:0] cfg_mask,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               in_valid,
  input  logic               d_in,
  input  logic               cnt_clr,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic               armed,
  output logic               cfg_err
);

  sm_state_e          state_q, state_d;
  logic [MAX_LEN-1:0] pattern_q, pattern_d;
  logic [MAX_LEN-1:0] mask_q, mask_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               mode_q, mode_d;
  // Only MAX_LEN-1 past bits matter; the incoming bit completes the window.
  logic [MAX_LEN-2:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic               match_q, match_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               armed_q, armed_d;
  logic               err_q, err_d;

  logic [MAX_LEN-1:0] hist_next;
  logic [LEN_W-1:0]   fill_next;
  logic               eq;
  logic               len_ok;
  logic               hit;

  assign hist_next = {hist_q, d_in};
  assign fill_next = (fill_q < len_q) ? fill_q + LEN_W'(1) : fill_q;
  assign len_ok    = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));

  seq_match_cmp #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_cmp (
    .hist_next (hist_next),
    .pattern   (pattern_q),
    .mask      (mask_q),
    .len       (len_q),
    .eq        (eq)
  );

  // Next-state: a load overrides everything; otherwise shift, evaluate and count.
  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    mask_d    = mask_q;
    len_d     = len_q;
    mode_d    = mode_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    match_d   = 1'b0;
    count_d   = count_q;
    armed_d   = armed_q;
    err_d     = err_q;
    hit       = 1'b0;

    if (cfg_load) begin
      pattern_d = cfg_pattern;
      mask_d    = cfg_mask;
      len_d     = cfg_len;
      mode_d    = cfg_overlap ? OVERLAP : NON_OVERLAP;
      state_d   = len_ok ? ARMED : ERR;
      armed_d   = len_ok;
      err_d     = !len_ok;
      hist_d    = '0;
      fill_d    = '0;
      count_d   = '0;
    end else begin
      if ((state_q == ARMED) && in_valid) begin
        hist_d = hist_next[MAX_LEN-2:0];
        fill_d = fill_next;
        hit    = (fill_next == len_q) && eq;
        // Non-overlapping mode demands a full fresh window after each match.
        if (hit && (mode_q == NON_OVERLAP)) begin
          fill_d = '0;
        end
      end
      match_d = hit;
      if (cnt_clr) begin
        count_d = '0;
      end else if (hit && (count_q != '1)) begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= UNCFG;
      pattern_q <= '0;
      mask_q    <= '0;
      len_q     <= '0;
      mode_q    <= NON_OVERLAP;
      hist_q    <= '0;
      fill_q    <= '0;
      match_q   <= 1'b0;
      count_q   <= '0;
      armed_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      mask_q    <= mask_d;
      len_q     <= len_d;
      mode_q    <= mode_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      match_q   <= match_d;
      count_q   <= count_d;
      armed_q   <= armed_d;
      err_q     <= err_d;
    end
  end

  assign match       = match_q;
  assign match_count = count_q;
  assign armed       = armed_q;
  assign cfg_err     = err_q;

endmodule
